// File: rtl/char_draw_pkg.sv
// Shared constants for the player character sprite drawer: sprite geometry,
// colours, lane-to-X mapping and the sequencer state encoding.
package char_draw_pkg;

  localparam int CHAR_W = 9;
  localparam int CHAR_H = 5;
  localparam int COL_BITS = 4;
  localparam int ROW_BITS = 3;

  // Y of the sprite bottom row; rows are drawn upward from here.
  localparam logic [6:0] BASE_Y = 7'd7;

  localparam logic [2:0] CHAR_COLOUR = 3'b111;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  localparam int NUM_LANES = 4;

  // Left edge of the sprite for each lane.
  localparam logic [7:0] LANE_X0 = 8'd6;
  localparam logic [7:0] LANE_X1 = 8'd24;
  localparam logic [7:0] LANE_X2 = 8'd78;
  localparam logic [7:0] LANE_X3 = 8'd132;

  typedef enum logic [2:0] {
    ST_INIT_DRAW = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ERASE     = 3'd2,
    ST_DRAW      = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  function automatic logic [7:0] lane_x(input logic [1:0] lane);
    logic [7:0] x;
    case (lane)
      2'd0:    x = LANE_X0;
      2'd1:    x = LANE_X1;
      2'd2:    x = LANE_X2;
      default: x = LANE_X3;
    endcase
    return x;
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Column/row raster counter for a W x H sprite. Column is the inner loop,
// row the outer loop. The counter wraps to (0,0) after the last pixel so
// back-to-back passes need no extra clear cycle.
module sprite_scan_counter
  import char_draw_pkg::*;
#(
  parameter int W = CHAR_W,
  parameter int H = CHAR_H
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                start,
  input  logic                step,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                last_pixel
);

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(W - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(H - 1);

  logic col_last;

  assign col_last   = (col == COL_LAST);
  assign last_pixel = col_last && (row == ROW_LAST);

  // Advance the raster position; start forces the origin.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col_last) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/char_draw_sequencer.sv
// Owns the VGA plot port for the player sprite. On a lane change it erases
// the sprite at the old lane in background colour, then redraws it at the
// new lane, one pixel per clock. A single pending slot remembers the most
// recent lane request that arrives while a move is in flight.
//
// Output timing: all pixel outputs are registered, so the pixel scanned in
// a given state cycle appears on XOut/YOut/ColourOut/Plot after that edge.
// Plot high means XOut/YOut/ColourOut carry a valid pixel for this cycle;
// there is no back-pressure from the VGA side.
module char_draw_sequencer
  import char_draw_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] CurrState,
  output logic [7:0] XOut,
  output logic [6:0] YOut,
  output logic [2:0] ColourOut,
  output logic       Plot,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] DebugState
);

  state_t                state;
  logic [1:0]            saved_pos;
  logic [1:0]            new_pos;
  logic [1:0]            pending_pos;
  logic                  pending_valid;

  logic [COL_BITS-1:0]   col;
  logic [ROW_BITS-1:0]   row;
  logic                  last_pixel;
  logic                  scan_start;
  logic                  scan_step;
  logic                  in_pass;

  logic                  curr_valid;
  logic [1:0]            curr_lane;
  logic [7:0]            pix_x;
  logic [6:0]            pix_y;

  assign DebugState = state;

  // Lanes 0..3 only; anything with the upper bits set is ignored.
  assign curr_valid = (CurrState[3:2] == 2'b00);
  assign curr_lane  = CurrState[1:0];

  assign in_pass    = (state == ST_INIT_DRAW) || (state == ST_ERASE) ||
                      (state == ST_DRAW);
  assign scan_step  = in_pass;
  assign scan_start = (state == ST_IDLE) || (state == ST_FINISH);

  // Pixel coordinate for the lane currently held in saved_pos.
  assign pix_x = lane_x(saved_pos) + {{(8 - COL_BITS){1'b0}}, col};
  assign pix_y = BASE_Y - {{(7 - ROW_BITS){1'b0}}, row};

  sprite_scan_counter #(
    .W(CHAR_W),
    .H(CHAR_H)
  ) u_scan (
    .Clock      (Clock),
    .Reset      (Reset),
    .start      (scan_start),
    .step       (scan_step),
    .col        (col),
    .row        (row),
    .last_pixel (last_pixel)
  );

  // Sequencer FSM with registered plot outputs and pending-request capture.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= ST_INIT_DRAW;
      saved_pos     <= 2'd0;
      new_pos       <= 2'd0;
      pending_pos   <= 2'd0;
      pending_valid <= 1'b0;
      XOut          <= 8'd0;
      YOut          <= 7'd0;
      ColourOut     <= 3'd0;
      Plot          <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      Done <= 1'b0;

      case (state)
        ST_INIT_DRAW: begin
          XOut      <= pix_x;
          YOut      <= pix_y;
          ColourOut <= CHAR_COLOUR;
          Plot      <= 1'b1;
          Busy      <= 1'b1;
          if (last_pixel) state <= ST_FINISH;
        end

        ST_IDLE: begin
          Plot <= 1'b0;
          Busy <= 1'b0;
          if (curr_valid && (curr_lane != saved_pos)) begin
            new_pos <= curr_lane;
            state   <= ST_ERASE;
          end
        end

        ST_ERASE: begin
          XOut      <= pix_x;
          YOut      <= pix_y;
          ColourOut <= BG_COLOUR;
          Plot      <= 1'b1;
          Busy      <= 1'b1;
          // The erase is done with the old lane; the draw pass uses the new one.
          if (last_pixel) begin
            saved_pos <= new_pos;
            state     <= ST_DRAW;
          end
        end

        ST_DRAW: begin
          XOut      <= pix_x;
          YOut      <= pix_y;
          ColourOut <= CHAR_COLOUR;
          Plot      <= 1'b1;
          Busy      <= 1'b1;
          if (last_pixel) state <= ST_FINISH;
        end

        ST_FINISH: begin
          Plot          <= 1'b0;
          Busy          <= 1'b1;
          Done          <= 1'b1;
          pending_valid <= 1'b0;
          if (pending_valid && (pending_pos != saved_pos)) begin
            new_pos <= pending_pos;
            state   <= ST_ERASE;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          Plot  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase

      // Requests arriving mid-pass go to the single pending slot; latest wins.
      if (in_pass && curr_valid && (curr_lane != new_pos)) begin
        pending_valid <= 1'b1;
        pending_pos   <= curr_lane;
      end
    end
  end

endmodule

// File: tb/tb_char_draw_sequencer.sv
// Directed bench for char_draw_sequencer: reset/init draw, lane moves,
// ignored requests, pending-request coalescing and mid-pass reset.
module tb_char_draw_sequencer;

  logic       Clock;
  logic       Reset;
  logic [3:0] CurrState;
  logic [7:0] XOut;
  logic [6:0] YOut;
  logic [2:0] ColourOut;
  logic       Plot;
  logic       Busy;
  logic       Done;
  logic [2:0] DebugState;

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;

  int n_checks;
  int n_fail;

  // {Plot, X, Y, Colour, Busy, Done}
  logic [20:0] exp_q[$];
  logic [20:0] obs;
  logic [2:0]  obs_st;

  assign obs    = {Plot, XOut, YOut, ColourOut, Busy, Done};
  assign obs_st = {Plot, Busy, Done};

  char_draw_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .CurrState  (CurrState),
    .XOut       (XOut),
    .YOut       (YOut),
    .ColourOut  (ColourOut),
    .Plot       (Plot),
    .Busy       (Busy),
    .Done       (Done),
    .DebugState (DebugState)
  );

  // Clock generation
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [7:0] tb_lane_x(input int lane);
    case (lane)
      0:       return 8'd6;
      1:       return 8'd24;
      2:       return 8'd78;
      default: return 8'd132;
    endcase
  endfunction

  // Expected output vector for pixel p (0..44) of a pass at the given lane.
  function automatic logic [20:0] pix_vec(input int lane, input int p,
                                          input logic [2:0] c);
    logic [7:0] x;
    logic [6:0] y;
    x = tb_lane_x(lane) + 8'(p % 9);
    y = 7'(7 - (p / 9));
    return {1'b1, x, y, c, 1'b1, 1'b0};
  endfunction

  task automatic push_pass(input int lane, input logic [2:0] c);
    for (int p = 0; p < 45; p++) exp_q.push_back(pix_vec(lane, p, c));
  endtask

  task automatic test_reset;
    logic [20:0] e;
    Reset     = 1'b1;
    CurrState = 4'd0;
    @(negedge Clock);
    @(negedge Clock);
    n_checks++;
    if (obs !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 21'd0);
    end
    n_checks++;
    if (DebugState !== S_INIT) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", DebugState, S_INIT);
    end
    Reset = 1'b0;
    push_pass(0, 3'b111);
    for (int i = 0; i < 45; i++) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL init_pixel %0d: got %h expected %h", i, obs, e);
      end
    end
    @(negedge Clock);
    n_checks++;
    if (obs_st !== 3'b011) begin
      n_fail++;
      $display("FAIL init_done: got %b expected 011", obs_st);
    end
    @(negedge Clock);
    n_checks++;
    if (obs_st !== 3'b000 || DebugState !== S_IDLE) begin
      n_fail++;
      $display("FAIL init_idle: got st=%b fsm=%0d expected 000/%0d", obs_st, DebugState, S_IDLE);
    end
  endtask

  task automatic test_ignore;
    CurrState = 4'd9;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      n_checks++;
      if (obs_st !== 3'b000) begin
        n_fail++;
        $display("FAIL ignore_invalid %0d: got %b expected 000", i, obs_st);
      end
    end
    CurrState = 4'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      n_checks++;
      if (obs_st !== 3'b000) begin
        n_fail++;
        $display("FAIL ignore_same %0d: got %b expected 000", i, obs_st);
      end
    end
  endtask

  task automatic test_move(input int from, input int to);
    logic [20:0] e;
    logic [7:0]  max_x;
    logic [6:0]  min_y;
    int          cyc;
    max_x = 8'd0;
    min_y = 7'd127;
    CurrState = 4'(to);
    @(negedge Clock);
    cyc = 0;
    n_checks++;
    if (obs_st !== 3'b000) begin
      n_fail++;
      $display("FAIL move_req_edge %0d->%0d: got %b expected 000", from, to, obs_st);
    end
    push_pass(from, 3'b000);
    push_pass(to, 3'b111);
    for (int i = 0; i < 90; i++) begin
      @(negedge Clock);
      cyc++;
      e = exp_q.pop_front();
      if (i >= 45) begin
        if (XOut > max_x) max_x = XOut;
        if (YOut < min_y) min_y = YOut;
      end
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL move_pixel %0d->%0d #%0d: got %h expected %h", from, to, i, obs, e);
      end
    end
    @(negedge Clock);
    cyc++;
    n_checks++;
    if (obs_st !== 3'b011 || cyc != 91) begin
      n_fail++;
      $display("FAIL move_done %0d->%0d: got %b at cycle %0d expected 011 at 91", from, to, obs_st, cyc);
    end
    n_checks++;
    if (max_x !== tb_lane_x(to) + 8'd8 || min_y !== 7'd3) begin
      n_fail++;
      $display("FAIL move_bounds %0d->%0d: got max_x=%0d min_y=%0d expected %0d/3", from, to, max_x, min_y, tb_lane_x(to) + 8'd8);
    end
    @(negedge Clock);
    n_checks++;
    if (obs_st !== 3'b000) begin
      n_fail++;
      $display("FAIL move_idle %0d->%0d: got %b expected 000", from, to, obs_st);
    end
  endtask

  task automatic test_back_to_back;
    logic [20:0] e;
    CurrState = 4'd1;
    @(negedge Clock);
    push_pass(0, 3'b000);
    push_pass(1, 3'b111);
    for (int i = 0; i < 90; i++) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL b2b_first #%0d: got %h expected %h", i, obs, e);
      end
      if (i == 5)  CurrState = 4'd3;
      if (i == 10) CurrState = 4'd2;
    end
    @(negedge Clock);
    n_checks++;
    if (obs_st !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_done1: got %b expected 011", obs_st);
    end
    push_pass(1, 3'b000);
    push_pass(2, 3'b111);
    for (int i = 0; i < 90; i++) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL b2b_second #%0d: got %h expected %h", i, obs, e);
      end
    end
    @(negedge Clock);
    n_checks++;
    if (obs_st !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_done2: got %b expected 011", obs_st);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      n_checks++;
      if (obs_st !== 3'b000) begin
        n_fail++;
        $display("FAIL b2b_quiet %0d: got %b expected 000", i, obs_st);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [20:0] e;
    CurrState = 4'd1;
    @(negedge Clock);
    push_pass(3, 3'b000);
    for (int p = 0; p <= 20; p++) exp_q.push_back(pix_vec(1, p, 3'b111));
    for (int i = 0; i < 66; i++) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL midrst_pixel #%0d: got %h expected %h", i, obs, e);
      end
    end
    #2;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 21'd0 || DebugState !== S_INIT) begin
      n_fail++;
      $display("FAIL midrst_async: got %h fsm=%0d expected 0/%0d", obs, DebugState, S_INIT);
    end
    CurrState = 4'd0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    push_pass(0, 3'b111);
    for (int i = 0; i < 45; i++) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL midrst_redraw #%0d: got %h expected %h", i, obs, e);
      end
    end
    @(negedge Clock);
    n_checks++;
    if (obs_st !== 3'b011) begin
      n_fail++;
      $display("FAIL midrst_done: got %b expected 011", obs_st);
    end
    @(negedge Clock);
    n_checks++;
    if (obs_st !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_idle: got %b expected 000", obs_st);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    Reset     = 1'b1;
    CurrState = 4'd0;
    test_reset();
    test_ignore();
    test_move(0, 2);
    test_move(2, 0);
    test_back_to_back();
    test_move(2, 3);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
